comp_seq: RTL and testbench
===========================

Name: comp_seq

Overview:
- Sequential, parametrised magnitude comparator with two operands, A and B, each W = CHUNK_W*NCHUNK bits wide.
- Operands are loaded MSB-chunk-first from a shared CHUNK_W-bit data bus. Each chunk is captured on a rising edge of that operand's load strobe (pushbutton-style, level held for many cycles).
- Supports unsigned and two's-complement compare and registers lo/eo/go with a valid flag.
- Successor to the fixed 4-bit pushbutton comparator; sits between the board switch/button inputs and the LED outputs.

Parameters:
- CHUNK_W, 4, width of data bus q and of each loaded chunk (>=1)
- NCHUNK, 2, chunks per operand (>=1); operand width W = CHUNK_W*NCHUNK

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  synchronous active-low reset
- ld_a  input  1  load strobe for A, level; the rising edge is the event
- ld_b  input  1  load strobe for B, level; the rising edge is the event
- q  input  CHUNK_W  chunk data, sampled on a load event
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned
- clear  input  1  synchronous restart, level, active-high
- a_full  output  1  all NCHUNK chunks of A captured
- b_full  output  1  all NCHUNK chunks of B captured
- valid  output  1  lo/eo/go hold a compare result
- lo  output  1  A < B
- eo  output  1  A == B
- go  output  1  A > B

Behaviour:
- Reset (rst_n=0 at posedge):
  - A, B, both chunk counters, a_full, b_full, valid, lo, eo and go all go to 0; state goes to LOAD.
  - Edge-detect registers prev_a/prev_b load the current ld_a/ld_b, so a strobe held through reset release produces no event.
- Edge detect: ev_a = ld_a & ~prev_a. prev_a <= ld_a every cycle. ev_b is formed the same way.
- Counters: cnt_a and cnt_b, width $clog2(NCHUNK+1), saturate at NCHUNK. a_full = (cnt_a==NCHUNK); b_full likewise.
- FSM states: LOAD, CMP, DONE.
- LOAD:
  - On ev_a with !a_full: A <= {A[W-CHUNK_W-1:0], q} (A <= q when NCHUNK=1) and cnt_a++.
  - ev_a with a_full is ignored. B follows the same rules.
  - ev_a and ev_b in the same cycle are both captured from the same q.
  - When both operands are full after this edge's updates, go to CMP at that edge.
- CMP, one cycle:
  - Compare A vs B, signed if signed_mode=1 at this posedge, else unsigned.
  - Register exactly one of lo/eo/go = 1, valid <= 1, go to DONE.
  - Load events in CMP are ignored.
- Latency: the result is visible one clock after the edge that captures the last chunk.
- DONE:
  - Outputs hold. All load events are ignored. A change of signed_mode does not re-evaluate.
  - Only clear or reset leaves DONE.
- clear=1 in any state:
  - Next cycle is LOAD with A, B, counters, valid, lo, eo and go = 0.
  - A load event in the same cycle as clear is dropped (clear wins).
  - prev_a/prev_b keep tracking the strobes normally.
- valid=0 implies lo=eo=go=0. valid=1 implies exactly one of lo/eo/go is 1.
- Reset mid-load or in DONE behaves as the reset case above; no partial operand survives.

Test Plan (defaults CHUNK_W=4, NCHUNK=2):
- Reset and edge masking: hold ld_a=1 during reset, release rst_n, keep ld_a=1 for 5 cycles -> a_full=0, A=0x00, valid=0; drop ld_a, then pulse ld_a with q=0x3 -> A=0x03, cnt_a=1.
- Unsigned compare: ld_a edges with q=0000 then 0111, ld_b edges with q=1111 then 0101, signed_mode=0 -> A=0x07, B=0xF5; one cycle after the last edge valid=1, lo=1, eo=0, go=0.
- Signed compare: same loads with signed_mode=1 -> go=1 (7 > -11); then a 3rd ld_a edge with q=0xF -> ignored, A stays 0x07, go stays 1.
- Simultaneous and overfill: ld_a and ld_b rise in the same cycle twice with q=0x9 -> A=B=0x99, eo=1. Separately, fill A, then a 3rd ld_a edge while B is partial -> A unchanged, state LOAD.
- Clear: after one A chunk (q=0x5), assert clear in the same cycle as an ld_b edge -> next cycle cnt_a=cnt_b=0, A=B=0, the ld_b chunk is dropped; a subsequent full load sequence compares correctly.
- Reset mid-DONE: reach valid=1, lo=1, then rst_n=0 for 1 cycle -> valid=lo=eo=go=0, a_full=b_full=0, state LOAD.

Source files
------------

// File: rtl/comp_seq.sv
// comp_seq: sequential magnitude comparator. Each operand is loaded MSB-chunk-first
// from a shared chunk bus on rising edges of its load strobe. The bus payload is a
// single scalar chunk, so it stays a plain port and needs no package.
module comp_seq #(
  parameter int unsigned CHUNK_W = 4,
  parameter int unsigned NCHUNK  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_a,
  input  logic               ld_b,
  input  logic [CHUNK_W-1:0] q,
  input  logic               signed_mode,
  input  logic               clear,
  output logic               a_full,
  output logic               b_full,
  output logic               valid,
  output logic               lo,
  output logic               eo,
  output logic               go
);

  localparam int unsigned W     = CHUNK_W * NCHUNK;
  localparam int unsigned CNT_W = $clog2(NCHUNK + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NCHUNK);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     w_a_nxt;
  logic [W-1:0]     w_b_nxt;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;
  logic [CNT_W-1:0] w_cnt_a_nxt;
  logic [CNT_W-1:0] w_cnt_b_nxt;
  logic             r_prev_a;
  logic             r_prev_b;
  logic             w_ev_a;
  logic             w_ev_b;
  logic             w_lt;
  logic             w_eq;
  logic             w_valid_nxt;
  logic             w_lo_nxt;
  logic             w_eo_nxt;
  logic             w_go_nxt;

  // Rising-edge detection on the held load strobes.
  assign w_ev_a = ld_a & ~r_prev_a;
  assign w_ev_b = ld_b & ~r_prev_b;

  // Magnitude relation of the stored operands in the selected number format.
  assign w_eq = (r_a == r_b);
  assign w_lt = signed_mode ? ($signed(r_a) < $signed(r_b)) : (r_a < r_b);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, operand capture and result decode.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_cnt_a_nxt = r_cnt_a;
    w_cnt_b_nxt = r_cnt_b;
    w_valid_nxt = valid;
    w_lo_nxt    = lo;
    w_eo_nxt    = eo;
    w_go_nxt    = go;

    if (clear) begin
      w_state_nxt = ST_LOAD;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
      w_cnt_a_nxt = '0;
      w_cnt_b_nxt = '0;
      w_valid_nxt = 1'b0;
      w_lo_nxt    = 1'b0;
      w_eo_nxt    = 1'b0;
      w_go_nxt    = 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          // Shift-in keeps the first chunk as the MSB chunk; also valid for NCHUNK=1.
          if (w_ev_a && !a_full) begin
            w_a_nxt     = W'(r_a << CHUNK_W) | W'(q);
            w_cnt_a_nxt = r_cnt_a + CNT_W'(1);
          end
          if (w_ev_b && !b_full) begin
            w_b_nxt     = W'(r_b << CHUNK_W) | W'(q);
            w_cnt_b_nxt = r_cnt_b + CNT_W'(1);
          end
          if ((w_cnt_a_nxt == CNT_FULL) && (w_cnt_b_nxt == CNT_FULL)) begin
            w_state_nxt = ST_CMP;
          end
        end
        ST_CMP: begin
          w_valid_nxt = 1'b1;
          w_eo_nxt    = w_eq;
          w_lo_nxt    = w_lt;
          w_go_nxt    = ~w_eq & ~w_lt;
          w_state_nxt = ST_DONE;
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_LOAD;
        end
      endcase
    end
  end

  // Datapath, counters, edge history and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_cnt_a  <= '0;
      r_cnt_b  <= '0;
      r_prev_a <= ld_a;
      r_prev_b <= ld_b;
      a_full   <= 1'b0;
      b_full   <= 1'b0;
      valid    <= 1'b0;
      lo       <= 1'b0;
      eo       <= 1'b0;
      go       <= 1'b0;
    end else begin
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_cnt_a  <= w_cnt_a_nxt;
      r_cnt_b  <= w_cnt_b_nxt;
      r_prev_a <= ld_a;
      r_prev_b <= ld_b;
      a_full   <= (w_cnt_a_nxt == CNT_FULL);
      b_full   <= (w_cnt_b_nxt == CNT_FULL);
      valid    <= w_valid_nxt;
      lo       <= w_lo_nxt;
      eo       <= w_eo_nxt;
      go       <= w_go_nxt;
    end
  end

endmodule

// File: tb/tb_comp_seq.sv
// tb_comp_seq: directed plus randomized stimulus against an integer-level reference model.
module tb_comp_seq;

  localparam int unsigned CW = 4;
  localparam int unsigned NC = 2;
  localparam int unsigned W  = CW * NC;

  logic          clk;
  logic          rst_n;
  logic          ld_a;
  logic          ld_b;
  logic [CW-1:0] q;
  logic          signed_mode;
  logic          clear;
  logic          a_full;
  logic          b_full;
  logic          valid;
  logic          lo;
  logic          eo;
  logic          go;

  int n_vec;
  int n_err;

  // Reference model state, kept as plain integers and chunk counts.
  int m_a;
  int m_b;
  int m_na;
  int m_nb;
  int m_phase;   // 0 collecting, 1 compare pending, 2 holding result
  int m_prev_a;
  int m_prev_b;
  int m_valid;
  int m_res;     // -1 A<B, 0 A==B, 1 A>B

  comp_seq #(.CHUNK_W(CW), .NCHUNK(NC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_a        (ld_a),
    .ld_b        (ld_b),
    .q           (q),
    .signed_mode (signed_mode),
    .clear       (clear),
    .a_full      (a_full),
    .b_full      (b_full),
    .valid       (valid),
    .lo          (lo),
    .eo          (eo),
    .go          (go)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_val(input int raw, input int sgn);
    if (sgn != 0 && raw >= (1 << (W - 1))) return raw - (1 << W);
    return raw;
  endfunction

  // Advance the model by one clock using the inputs that were present at the edge.
  task automatic model_step();
    int ea;
    int eb;
    int va;
    int vb;
    ea = (ld_a && !m_prev_a) ? 1 : 0;
    eb = (ld_b && !m_prev_b) ? 1 : 0;
    m_prev_a = int'(ld_a);
    m_prev_b = int'(ld_b);
    if (!rst_n || clear) begin
      m_a = 0; m_b = 0; m_na = 0; m_nb = 0;
      m_phase = 0; m_valid = 0; m_res = 0;
    end else if (m_phase == 0) begin
      if (ea != 0 && m_na < NC) begin
        m_a = ((m_a * (1 << CW)) + int'(q)) % (1 << W);
        m_na++;
      end
      if (eb != 0 && m_nb < NC) begin
        m_b = ((m_b * (1 << CW)) + int'(q)) % (1 << W);
        m_nb++;
      end
      if (m_na == NC && m_nb == NC) m_phase = 1;
    end else if (m_phase == 1) begin
      va = to_val(m_a, int'(signed_mode));
      vb = to_val(m_b, int'(signed_mode));
      m_res = (va < vb) ? -1 : ((va == vb) ? 0 : 1);
      m_valid = 1;
      m_phase = 2;
    end
  endtask

  // One clock: drive inputs, take the edge, update model, compare all outputs.
  task automatic cyc(input logic la, input logic lb, input logic [CW-1:0] qq,
                     input logic sm, input logic clr, input logic rn);
    logic [5:0] exp_v;
    logic [5:0] obs_v;
    ld_a = la; ld_b = lb; q = qq; signed_mode = sm; clear = clr; rst_n = rn;
    @(posedge clk);
    #1;
    model_step();
    exp_v = {m_na == NC, m_nb == NC, m_valid != 0,
             m_valid != 0 && m_res < 0, m_valid != 0 && m_res == 0, m_valid != 0 && m_res > 0};
    obs_v = {a_full, b_full, valid, lo, eo, go};
    n_vec++;
    assert (obs_v === exp_v) else begin
      n_err++;
      $error("FAIL outs {af,bf,v,lo,eo,go} t=%0t observed=%b expected=%b", $time, obs_v, exp_v);
    end
  endtask

  // Spot check of a single output against a directed constant expectation.
  task automatic chk(input string tag, input logic obs, input logic exp_b);
    n_vec++;
    assert (obs === exp_b) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_b);
    end
  endtask

  task automatic load_pair(input logic [CW-1:0] a1, input logic [CW-1:0] a0,
                           input logic [CW-1:0] b1, input logic [CW-1:0] b0, input logic sm);
    cyc(1, 0, a1, sm, 0, 1); cyc(0, 0, a1, sm, 0, 1);
    cyc(1, 0, a0, sm, 0, 1); cyc(0, 0, a0, sm, 0, 1);
    cyc(0, 1, b1, sm, 0, 1); cyc(0, 0, b1, sm, 0, 1);
    cyc(0, 1, b0, sm, 0, 1);
    cyc(0, 0, b0, sm, 0, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_phase = 0;
    m_prev_a = 0; m_prev_b = 0; m_valid = 0; m_res = 0;
    ld_a = 0; ld_b = 0; q = '0; signed_mode = 0; clear = 0; rst_n = 0;

    // Strobe held through reset release must not count as an edge.
    cyc(1, 0, 4'h3, 0, 0, 0);
    cyc(1, 0, 4'h3, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 0, 4'h3, 0, 0, 1);
    chk("masked_a_full", a_full, 1'b0);
    chk("masked_valid", valid, 1'b0);
    cyc(0, 0, 4'h3, 0, 0, 1);
    cyc(1, 0, 4'h3, 0, 0, 1);
    cyc(0, 0, 4'h3, 0, 0, 1);
    cyc(0, 0, 4'h0, 0, 1, 1);

    // Unsigned: 0x07 vs 0xF5.
    load_pair(4'h0, 4'h7, 4'hF, 4'h5, 0);
    chk("uns_lo", lo, 1'b1);
    chk("uns_valid", valid, 1'b1);
    cyc(0, 0, 4'h0, 0, 1, 1);

    // Signed: 7 vs -11, then an extra A edge is ignored.
    load_pair(4'h0, 4'h7, 4'hF, 4'h5, 1);
    chk("sgn_go", go, 1'b1);
    cyc(1, 0, 4'hF, 1, 0, 1);
    cyc(0, 0, 4'hF, 0, 0, 1);
    chk("sgn_hold_go", go, 1'b1);
    cyc(0, 0, 4'h0, 0, 1, 1);

    // Simultaneous edges capture the same chunk into both operands.
    cyc(1, 1, 4'h9, 0, 0, 1); cyc(0, 0, 4'h9, 0, 0, 1);
    cyc(1, 1, 4'h9, 0, 0, 1); cyc(0, 0, 4'h9, 0, 0, 1);
    chk("simul_eo", eo, 1'b1);
    cyc(0, 0, 4'h0, 0, 1, 1);

    // Overfill A while B is partial: stays in load, then completes later.
    cyc(1, 0, 4'h1, 0, 0, 1); cyc(0, 0, 4'h1, 0, 0, 1);
    cyc(1, 0, 4'h2, 0, 0, 1); cyc(0, 0, 4'h2, 0, 0, 1);
    cyc(0, 1, 4'h1, 0, 0, 1); cyc(0, 0, 4'h1, 0, 0, 1);
    cyc(1, 0, 4'hF, 0, 0, 1); cyc(0, 0, 4'hF, 0, 0, 1);
    chk("overfill_valid", valid, 1'b0);
    cyc(0, 1, 4'h2, 0, 0, 1); cyc(0, 0, 4'h2, 0, 0, 1);
    chk("overfill_eo", eo, 1'b1);
    cyc(0, 0, 4'h0, 0, 1, 1);

    // Clear wins over a same-cycle load edge.
    cyc(1, 0, 4'h5, 0, 0, 1); cyc(0, 0, 4'h5, 0, 0, 1);
    cyc(0, 1, 4'h6, 0, 1, 1);
    chk("clear_a_full", a_full, 1'b0);
    chk("clear_b_full", b_full, 1'b0);
    cyc(0, 0, 4'h6, 0, 0, 1);
    load_pair(4'h8, 4'h0, 4'h7, 4'hF, 1);
    chk("after_clear_lo", lo, 1'b1);

    // Reset while holding a result.
    cyc(0, 0, 4'h0, 0, 0, 0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_lo", lo, 1'b0);
    cyc(0, 0, 4'h0, 0, 0, 1);

    // Randomized traffic with occasional clear, reset and format flips.
    for (int i = 0; i < 3000; i++) begin
      cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
          CW'($urandom), logic'($urandom_range(0, 1)),
          logic'($urandom_range(0, 29) == 0), logic'($urandom_range(0, 149) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
